// File: rtl/gf180mcu_fd_io__asig_pkg.sv
// ASIG pad-ring shared definitions.
// State encoding and default switch timing.
package gf180mcu_fd_io__asig_pkg;

   typedef logic [2:0] asig_state_t;

   localparam asig_state_t ST_IDLE    = 3'd0;
   localparam asig_state_t ST_BREAK   = 3'd1;
   localparam asig_state_t ST_MAKE    = 3'd2;
   localparam asig_state_t ST_GRANT   = 3'd3;
   localparam asig_state_t ST_RELEASE = 3'd4;

   localparam int ASIG_BREAK_CYC  = 4;
   localparam int ASIG_SETTLE_CYC = 16;

endpackage

// File: rtl/gf180mcu_fd_io__asig_sw_arb_if.sv
// Requester-side bundle of the ASIG pad switch arbiter.
// master = requesters, slave = arbiter.
interface gf180mcu_fd_io__asig_sw_arb_if #(
   parameter int NREQ = 4
) ();

   logic                      EN;
   logic [NREQ-1:0]           REQ;
   logic [NREQ-1:0]           GNT;
   logic [NREQ-1:0]           SW_EN;
   logic                      DCHG;
   logic                      BUSY;
   logic [$clog2(NREQ)-1:0]   OWNER;
   logic                      TIMEOUT;

   modport master (
      output EN, REQ,
      input  GNT, SW_EN, DCHG, BUSY, OWNER, TIMEOUT
   );

   modport slave (
      input  EN, REQ,
      output GNT, SW_EN, DCHG, BUSY, OWNER, TIMEOUT
   );

endinterface

// File: rtl/gf180mcu_fd_io__asig_rr_pick.sv
// Rotate-priority picker: first set req at index >= ptr,
// wrapping around.
module gf180mcu_fd_io__asig_rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic            vld,
   output logic [IW-1:0]   idx
);

   function automatic logic [IW-1:0] wrap(
      input logic [IW-1:0] p,
      input int            k
   );
      int s;
      s = int'(p) + k;
      if (s >= NREQ) s = s - NREQ;
      return IW'(s);
   endfunction

   // scan downwards so the lowest offset wins
   always_comb begin
      vld = 1'b0;
      idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[wrap(ptr, k)]) begin
            vld = 1'b1;
            idx = wrap(ptr, k);
         end
      end
   end

endmodule

// File: rtl/gf180mcu_fd_io__asig_sw_arb.sv
// ASIG5V pad sharing arbiter: break-before-make switch
// sequencing with discharge, settle and round-robin grant.
module gf180mcu_fd_io__asig_sw_arb
   import gf180mcu_fd_io__asig_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int BREAK_CYC  = ASIG_BREAK_CYC,
   parameter int SETTLE_CYC = ASIG_SETTLE_CYC,
   parameter int MAX_HOLD   = 0,
   parameter int CNT_W      = 8
) (
   input logic CLK,
   input logic RN,
   gf180mcu_fd_io__asig_sw_arb_if.slave bus
);

   localparam int IW = $clog2(NREQ);
   localparam logic [CNT_W-1:0] BRK_INI = CNT_W'(BREAK_CYC - 1);
   localparam logic [CNT_W-1:0] SET_INI = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST =
      CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
   localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

   asig_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    pick_idx;
   logic             pick_vld;
   logic             keep;
   logic             others;
   logic [NREQ-1:0]  own_oh, nxt_oh;
   logic [NREQ-1:0]  swen_d, swen_q;
   logic [NREQ-1:0]  gnt_d, gnt_q;
   logic             dchg_d, dchg_q;
   logic             busy_d, busy_q;
   logic             tmo_d, tmo_q;

   gf180mcu_fd_io__asig_rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req (bus.REQ),
      .ptr (ptr_q),
      .vld (pick_vld),
      .idx (pick_idx)
   );

   assign own_oh = NREQ'(1) << owner_q;
   assign nxt_oh = NREQ'(1) << owner_d;
   assign keep   = bus.EN && bus.REQ[owner_q];
   assign others = |(bus.REQ & ~own_oh);

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         swen_q  <= '0;
         gnt_q   <= '0;
         dchg_q  <= 1'b0;
         busy_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         swen_q  <= swen_d;
         gnt_q   <= gnt_d;
         dchg_q  <= dchg_d;
         busy_q  <= busy_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      tmo_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.EN && pick_vld) begin
               state_d = ST_BREAK;
               owner_d = pick_idx;
               cnt_d   = BRK_INI;
            end
         end
         ST_BREAK: begin
            if (!keep) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = ST_MAKE;
               cnt_d   = SET_INI;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_MAKE: begin
            if (!keep) begin
               state_d = ST_RELEASE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = ST_GRANT;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_GRANT: begin
            // cnt doubles as the hold timer while others wait
            if (!keep) begin
               state_d = ST_RELEASE;
               cnt_d   = '0;
            end else if (MAX_HOLD > 0 && others) begin
               if (cnt_q == HOLD_LAST) begin
                  state_d = ST_RELEASE;
                  cnt_d   = '0;
                  tmo_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               cnt_d = '0;
            end
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      swen_d = '0;
      gnt_d  = '0;
      dchg_d = 1'b0;
      busy_d = (state_d != ST_IDLE);
      unique case (state_d)
         ST_BREAK: dchg_d = 1'b1;
         ST_MAKE:  swen_d = nxt_oh;
         ST_GRANT: begin
            swen_d = nxt_oh;
            gnt_d  = nxt_oh;
         end
         default: ;
      endcase
   end

   assign bus.GNT     = gnt_q;
   assign bus.SW_EN   = swen_q;
   assign bus.DCHG    = dchg_q;
   assign bus.BUSY    = busy_q;
   assign bus.OWNER   = owner_q;
   assign bus.TIMEOUT = tmo_q;

endmodule

// File: tb/tb_gf180mcu_fd_io__asig_sw_arb.sv
// Directed bench for the ASIG pad switch arbiter:
// default instance plus a MAX_HOLD=8 instance.
module tb_gf180mcu_fd_io__asig_sw_arb;

   logic CLK = 1'b0;
   logic RN  = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   bit   mon_on = 1'b0;
   int   zrun0 = 100;
   int   zrun1 = 100;
   int   rr_exp [4] = '{0, 1, 3, 0};

   always #5 CLK = ~CLK;

   gf180mcu_fd_io__asig_sw_arb_if #(.NREQ(4)) b0 ();
   gf180mcu_fd_io__asig_sw_arb_if #(.NREQ(4)) b1 ();

   gf180mcu_fd_io__asig_sw_arb #(
      .NREQ (4)
   ) u0 (
      .CLK (CLK),
      .RN  (RN),
      .bus (b0)
   );

   gf180mcu_fd_io__asig_sw_arb #(
      .NREQ     (4),
      .MAX_HOLD (8)
   ) u1 (
      .CLK (CLK),
      .RN  (RN),
      .bus (b1)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge CLK);
   endtask

   task automatic wait_gnt0(input string tag);
      bit ok = 1'b0;
      for (int c = 0; c < 60 && !ok; c++) begin
         step();
         ok = (b0.GNT != '0);
      end
      chk(tag, 32'(ok), 1);
   endtask

   task automatic wait_gnt1(input string tag);
      bit ok = 1'b0;
      for (int c = 0; c < 60 && !ok; c++) begin
         step();
         ok = (b1.GNT != '0);
      end
      chk(tag, 32'(ok), 1);
   endtask

   // safety invariants on both instances, every cycle
   always @(negedge CLK) begin
      if (RN && mon_on) begin
         chk("inv_onehot0", 32'(b0.SW_EN & (b0.SW_EN - 4'd1)), 0);
         chk("inv_dchg0", 32'((|b0.SW_EN) & b0.DCHG), 0);
         chk("inv_gnt0", 32'(b0.GNT & ~b0.SW_EN), 0);
         chk("inv_tmo0", 32'(b0.TIMEOUT), 0);
         if (b0.SW_EN != '0 && zrun0 > 0)
            chk("inv_bbm0", 32'(zrun0 >= 4), 1);
         zrun0 = (b0.SW_EN == '0) ? zrun0 + 1 : 0;
         chk("inv_onehot1", 32'(b1.SW_EN & (b1.SW_EN - 4'd1)), 0);
         chk("inv_dchg1", 32'((|b1.SW_EN) & b1.DCHG), 0);
         chk("inv_gnt1", 32'(b1.GNT & ~b1.SW_EN), 0);
         if (b1.SW_EN != '0 && zrun1 > 0)
            chk("inv_bbm1", 32'(zrun1 >= 4), 1);
         zrun1 = (b1.SW_EN == '0) ? zrun1 + 1 : 0;
      end
   end

   initial begin
      bit   seen;
      int   brk;
      bit   ok;
      b0.EN = 1'b1;
      b0.REQ = '0;
      b1.EN = 1'b1;
      b1.REQ = '0;
      repeat (3) step();
      chk("rst_gnt", 32'(b0.GNT), 0);
      chk("rst_swen", 32'(b0.SW_EN), 0);
      chk("rst_dchg", 32'(b0.DCHG), 0);
      chk("rst_busy", 32'(b0.BUSY), 0);
      chk("rst_owner", 32'(b0.OWNER), 0);
      chk("rst_tmo", 32'(b1.TIMEOUT), 0);
      RN = 1'b1;
      mon_on = 1'b1;
      step();

      // single request latency
      b0.REQ = 4'b0100;
      for (int m = 1; m <= 21; m++) begin
         step();
         chk("lat_dchg", 32'(b0.DCHG), 32'(m <= 4));
         chk("lat_swen", 32'(b0.SW_EN), (m >= 5) ? 32'h4 : 32'h0);
         chk("lat_gnt", 32'(b0.GNT), (m >= 21) ? 32'h4 : 32'h0);
         chk("lat_busy", 32'(b0.BUSY), 1);
      end
      chk("lat_owner", 32'(b0.OWNER), 2);

      // release then same requester comes straight back
      b0.REQ = '0;
      step();
      chk("rel_gnt", 32'(b0.GNT), 0);
      chk("rel_swen", 32'(b0.SW_EN), 0);
      chk("rel_busy", 32'(b0.BUSY), 1);
      b0.REQ = 4'b0100;
      for (int m = 2; m <= 7; m++) begin
         step();
         chk("rereq_swen", 32'(b0.SW_EN), (m == 7) ? 32'h4 : 32'h0);
         chk("rereq_dchg", 32'(b0.DCHG), 32'(m >= 3 && m <= 6));
      end

      // asynchronous reset while granted
      wait_gnt0("rst_wait");
      #2 RN = 1'b0;
      #1;
      chk("arst_swen", 32'(b0.SW_EN), 0);
      chk("arst_gnt", 32'(b0.GNT), 0);
      chk("arst_dchg", 32'(b0.DCHG), 0);
      b0.REQ = '0;
      step();
      RN = 1'b1;
      #1;
      chk("arst_owner", 32'(b0.OWNER), 0);
      chk("arst_busy", 32'(b0.BUSY), 0);
      step();

      // round robin with 1011 held
      b0.REQ = 4'b1011;
      for (int g = 0; g < 4; g++) begin
         brk = 0;
         ok  = 1'b0;
         for (int c = 0; c < 60 && !ok; c++) begin
            step();
            if (b0.GNT != '0) ok = 1'b1;
            else if (b0.SW_EN == '0 && b0.DCHG) brk++;
         end
         chk("rr_wait", 32'(ok), 1);
         chk("rr_owner", 32'(b0.OWNER), rr_exp[g]);
         chk("rr_gnt", 32'(b0.GNT), 32'(1) << rr_exp[g]);
         chk("rr_break", brk, 4);
         b0.REQ = b0.REQ & ~(4'b0001 << rr_exp[g]);
         step();
         b0.REQ = (g == 3) ? 4'b0000 : 4'b1011;
      end
      repeat (3) step();

      // abort during BREAK
      b0.REQ = 4'b0010;
      step();
      step();
      chk("abk_dchg", 32'(b0.DCHG), 1);
      b0.REQ = '0;
      step();
      chk("abk_busy", 32'(b0.BUSY), 0);
      chk("abk_dchg0", 32'(b0.DCHG), 0);
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         step();
         seen |= (b0.SW_EN != '0);
      end
      chk("abk_noswen", 32'(seen), 0);

      // abort during MAKE
      b0.REQ = 4'b0010;
      repeat (5) step();
      chk("amk_swen", 32'(b0.SW_EN), 32'h2);
      b0.REQ = '0;
      step();
      chk("amk_rel_swen", 32'(b0.SW_EN), 0);
      chk("amk_rel_busy", 32'(b0.BUSY), 1);
      seen = 1'b0;
      for (int c = 0; c < 25; c++) begin
         step();
         seen |= (b0.GNT != '0);
      end
      chk("amk_nognt", 32'(seen), 0);

      // EN dropped in GRANT
      b0.REQ = 4'b0010;
      wait_gnt0("en_wait");
      b0.EN = 1'b0;
      step();
      chk("en_rel_gnt", 32'(b0.GNT), 0);
      chk("en_rel_busy", 32'(b0.BUSY), 1);
      step();
      chk("en_idle", 32'(b0.BUSY), 0);
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         seen |= b0.BUSY;
      end
      chk("en_ignored", 32'(seen), 0);
      b0.REQ = '0;
      b0.EN = 1'b1;

      // hold timeout on the MAX_HOLD=8 instance
      b1.REQ = 4'b0001;
      wait_gnt1("tmo_wait");
      chk("tmo_owner0", 32'(b1.OWNER), 0);
      b1.REQ = 4'b1001;
      for (int m = 1; m <= 9; m++) begin
         step();
         chk("tmo_pulse", 32'(b1.TIMEOUT), 32'(m == 8));
         chk("tmo_gnt", 32'(b1.GNT), (m < 8) ? 32'h1 : 32'h0);
      end
      wait_gnt1("tmo_wait3");
      chk("tmo_owner3", 32'(b1.OWNER), 3);
      chk("tmo_gnt3", 32'(b1.GNT), 32'h8);
      b1.REQ = '0;

      // random traffic under the invariant monitor
      for (int r = 0; r < 40; r++) begin
         b0.REQ = 4'($urandom);
         b0.EN  = ($urandom_range(0, 7) != 0);
         b1.REQ = 4'($urandom);
         repeat ($urandom_range(1, 30)) step();
      end
      b0.REQ = '0;
      b0.EN  = 1'b1;
      b1.REQ = '0;
      repeat (4) step();
      chk("end_idle0", 32'(b0.BUSY), 0);
      chk("end_idle1", 32'(b1.BUSY), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
